servo_pwm_multi: RTL and testbench
==================================

# servo_pwm_multi

Parametrised multi-channel RC-servo pulse generator with per-channel slew-rate-limited motion toward a programmable target position. Each channel emits one pulse per frame, with width set by its current position. A host writes targets through a valid/ready port, and the current positions ramp in both directions, one LSB per `RAMP_FRAMES` frames. It sits between the user-input decode logic and the servo pins of the top-level wrapper, and supersedes the single-channel, up-only servo tester.

## Interface
- `N_CH`, 4: number of independent channels (1..8).
- `POS_W`, 8: position/target width in bits.
- `PERIOD_CYCLES`, 200000: frame length in clocks (20 ms at 10 MHz).
- `MIN_PULSE`, 10000: pulse width in clocks at position 0.
- `STEP_CYCLES`, 40: extra pulse clocks per position LSB.
- `RAMP_FRAMES`, 1: frames per one-LSB step of the current position (≥1).
- `clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `set_valid` in 1: write request.
- `set_ready` out 1: write can be accepted this cycle.
- `set_chan` in 3: target channel index.
- `set_value` in POS_W: new target position.
- `set_snap` in 1: with the write, also load the current position (no ramp).
- `set_en` in 1: with the write, the channel enable bit.
- `pwm` out N_CH: servo pulse outputs.
- `settled` out N_CH: the channel's current position equals its target.
- `frame_start` out 1: one-cycle strobe on the first clock of each frame.

## Operation
- **Frame counter** `fcnt` runs 0..PERIOD_CYCLES−1 and wraps. Its width is `$clog2(PERIOD_CYCLES)`.
- **Boundary cycle:** the cycle where `fcnt == PERIOD_CYCLES−1`.
- **Write handshake:** a write is accepted when `set_valid && set_ready`.
  - Accepting a write loads `target[set_chan]` and `en_req[set_chan]`.
  - If `set_snap` is high, it also loads `cur[set_chan]`.
  - If `set_chan >= N_CH`, the write is accepted and discarded.
- **Ready rule:** `set_ready` = 0 on the boundary cycle, 1 otherwise. Writes never collide with the ramp update.
- **Ramp:** each channel has a frame divider `rdiv` counting 0..RAMP_FRAMES−1, which advances on every boundary cycle. When `rdiv == RAMP_FRAMES−1` on a boundary cycle:
  - `cur` steps +1 if `cur < target`, −1 if `cur > target`, and is unchanged if equal.
  - The direction may reverse between steps when the target changes.
  - `rdiv` of a disabled channel is held at 0 and its `cur` is frozen.
- **Enable:** `en_act` latches `en_req` on the boundary cycle, so enable changes affect whole frames only (no runt pulses).
- **Pulse width:** W = MIN_PULSE + cur·STEP_CYCLES, computed in `$clog2(PERIOD_CYCLES)` bits without overflow.
  - `pwm[i]` is high for exactly W clocks starting with `frame_start`, when `en_act[i]` = 1. Otherwise it is low for the whole frame.
  - `cur` only changes on the boundary, so W is constant within a frame.
- **Settled:** `settled[i]` = (`cur[i] == target[i]`), independent of enable.
- **Elaboration check:** MIN_PULSE + (2^POS_W−1)·STEP_CYCLES ≤ PERIOD_CYCLES−1, else `$error`.
- **Reset values:**
  - `fcnt` = PERIOD_CYCLES−1; `cur`, `target`, `rdiv`, `en_req`, `en_act` all 0.
  - `pwm` = 0, `frame_start` = 0, `set_ready` = 0 (combinational from `fcnt`), `settled` = all 1.
  - Assertion mid-frame forces these values immediately. A partial pulse is truncated.

## Timing
- The first rising edge after `rst_n` rises is a boundary; `frame_start` and frame 0 begin on the next cycle.
- `pwm`, `frame_start` and `settled` are registered. `pwm` rises in the same cycle as `frame_start` and falls exactly W cycles later.
- A write accepted in cycle t updates `target` at t+1 and `settled` at t+2.
- A write at t that changes `en_req` takes effect at the first `frame_start` after t.
- A `set_snap` write accepted mid-frame changes `pwm` width from the next frame only.
- Ramp latency: |target−cur|·RAMP_FRAMES frames until `settled` = 1.

## Structure
- Package `servo_pkg` holds:
  - the default parameter constants;
  - a `pos_t` typedef sized by POS_W;
  - a `pulse_width()` function that computes W.
- One sub-module, `servo_channel`, instanced N_CH times. It holds `target`, `cur`, `rdiv`, `en_req`/`en_act`, the width comparator and the `pwm`/`settled` registers.
- The top level holds `fcnt`, `set_ready`, the channel decode and `frame_start`.

## Test plan
- **Reset/idle:** reset, enable ch0 at target 0 → `pwm[0]` high exactly 10000 clocks per frame, period 200000; `settled` = 1111.
- **Ramp up/down:** ch1 target 5 with RAMP_FRAMES=2 → W = 10000, 10000, 10040, 10040, …, 10200; then target 3 → decreases 40 clocks per 2 frames until `settled[1]`.
- **Snap and reversal:** snap ch2 to 255 → next frame W = 20200. Mid-ramp target reversal steps the opposite way at the next ramp boundary.
- **Handshake boundary:** hold `set_valid` across a boundary → `set_ready` = 0 for exactly that cycle. The write lands one cycle later and is not lost or duplicated.
- **Enable/invalid channel:** disable ch3 mid-pulse → current pulse completes, next frame low. A write to `set_chan` = 6 is accepted, with no state change.
- **Async reset mid-pulse:** drop `rst_n` at `fcnt` = 5000 → `pwm` = 0 within the same cycle. After release, the frame restarts per Timing.

Source files
------------

// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared constants, position type and pulse-width helper for the servo PWM block
package servo_pkg;

    localparam int DEF_N_CH          = 4;
    localparam int DEF_POS_W         = 8;
    localparam int DEF_PERIOD_CYCLES = 200000;
    localparam int DEF_MIN_PULSE     = 10000;
    localparam int DEF_STEP_CYCLES   = 40;
    localparam int DEF_RAMP_FRAMES   = 1;

    typedef logic [DEF_POS_W-1:0] pos_t;

    // Pulse width in clocks for a given position.
    function automatic int pulse_width(input int pos, input int min_pulse, input int step_cycles);
        return min_pulse + pos * step_cycles;
    endfunction

endpackage

// File: rtl/servo_channel.sv
// rtl/servo_channel.sv - one servo channel: target/current position, slew ramp, enable and pulse output
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   boundary_i    high on the last cycle of a frame
//   fcnt_i        frame counter value of the current cycle
//   wr_i          accepted write addressed to this channel
//   wr_snap_i     write also loads the current position
//   wr_en_i       enable bit carried by the write
//   wr_value_i    target position carried by the write
//   pwm_o         registered pulse output
//   settled_o     registered (current == target)
module servo_channel
    import servo_pkg::*;
#(
    parameter int POS_W         = DEF_POS_W,
    parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
    parameter int MIN_PULSE     = DEF_MIN_PULSE,
    parameter int STEP_CYCLES   = DEF_STEP_CYCLES,
    parameter int RAMP_FRAMES   = DEF_RAMP_FRAMES,
    localparam int FW           = $clog2(PERIOD_CYCLES),
    localparam int RW           = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             boundary_i,
    input  logic [FW-1:0]    fcnt_i,
    input  logic             wr_i,
    input  logic             wr_snap_i,
    input  logic             wr_en_i,
    input  logic [POS_W-1:0] wr_value_i,
    output logic             pwm_o,
    output logic             settled_o
);

    logic [POS_W-1:0] target_q, target_d;
    logic [POS_W-1:0] cur_q, cur_d;
    logic [RW-1:0]    rdiv_q, rdiv_d;
    logic             en_req_q, en_req_d;
    logic             en_act_q, en_act_d;
    logic [FW-1:0]    w_q, w_d;
    logic             pwm_q, pwm_d;
    logic             settled_q;
    logic [FW:0]      fcnt_nx;

    // Frame counter value of the next cycle (never wraps here: only used off the boundary).
    assign fcnt_nx = {1'b0, fcnt_i} + {{FW{1'b0}}, 1'b1};

    always_comb begin
        target_d = target_q;
        en_req_d = en_req_q;
        cur_d    = cur_q;
        rdiv_d   = rdiv_q;
        en_act_d = en_act_q;
        w_d      = w_q;
        pwm_d    = 1'b0;

        // Writes are never accepted on the boundary cycle, so they cannot race the ramp step.
        if (wr_i) begin
            target_d = wr_value_i;
            en_req_d = wr_en_i;
            if (wr_snap_i) begin
                cur_d = wr_value_i;
            end
        end

        if (boundary_i) begin
            // Ramping is gated by the enable of the frame that is ending.
            if (!en_act_q) begin
                rdiv_d = '0;
            end else if (rdiv_q == RW'(RAMP_FRAMES - 1)) begin
                rdiv_d = '0;
                if (cur_q < target_q) begin
                    cur_d = cur_q + {{(POS_W-1){1'b0}}, 1'b1};
                end else if (cur_q > target_q) begin
                    cur_d = cur_q - {{(POS_W-1){1'b0}}, 1'b1};
                end
            end else begin
                rdiv_d = rdiv_q + {{(RW-1){1'b0}}, 1'b1};
            end
            en_act_d = en_req_q;
            // Width is frozen per frame so a mid-frame snap cannot reshape the pulse in flight.
            w_d      = FW'(pulse_width(int'(cur_d), MIN_PULSE, STEP_CYCLES));
            pwm_d    = en_act_d && (w_d != '0);
        end else begin
            pwm_d = en_act_q && (fcnt_nx < {1'b0, w_q});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q  <= '0;
            cur_q     <= '0;
            rdiv_q    <= '0;
            en_req_q  <= 1'b0;
            en_act_q  <= 1'b0;
            w_q       <= FW'(MIN_PULSE);
            pwm_q     <= 1'b0;
            settled_q <= 1'b1;
        end else begin
            target_q  <= target_d;
            cur_q     <= cur_d;
            rdiv_q    <= rdiv_d;
            en_req_q  <= en_req_d;
            en_act_q  <= en_act_d;
            w_q       <= w_d;
            pwm_q     <= pwm_d;
            settled_q <= (cur_q == target_q);
        end
    end

    assign pwm_o     = pwm_q;
    assign settled_o = settled_q;

endmodule

// File: rtl/servo_pwm_multi.sv
// rtl/servo_pwm_multi.sv - multi-channel RC-servo pulse generator with slew-limited positioning
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   set_valid     write request
//   set_ready     write accepted this cycle (low on the frame boundary cycle)
//   set_chan      channel index of the write (>= N_CH is accepted and dropped)
//   set_value     new target position
//   set_snap      write also loads the current position
//   set_en        channel enable carried by the write
//   pwm           per-channel pulse outputs
//   settled       per-channel current == target
//   frame_start   one-cycle strobe on the first clock of each frame
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int N_CH          = DEF_N_CH,
    parameter int POS_W         = DEF_POS_W,
    parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
    parameter int MIN_PULSE     = DEF_MIN_PULSE,
    parameter int STEP_CYCLES   = DEF_STEP_CYCLES,
    parameter int RAMP_FRAMES   = DEF_RAMP_FRAMES,
    localparam int FW           = $clog2(PERIOD_CYCLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_valid,
    output logic             set_ready,
    input  logic [2:0]       set_chan,
    input  logic [POS_W-1:0] set_value,
    input  logic             set_snap,
    input  logic             set_en,
    output logic [N_CH-1:0]  pwm,
    output logic [N_CH-1:0]  settled,
    output logic             frame_start
);

    if (MIN_PULSE + ((2 ** POS_W) - 1) * STEP_CYCLES > PERIOD_CYCLES - 1) begin : g_bad_params
        $error("servo_pwm_multi: widest pulse does not fit in the frame");
    end

    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          frame_start_q;
    logic          boundary;
    logic          wr_accept;

    assign boundary  = (fcnt_q == FW'(PERIOD_CYCLES - 1));
    assign set_ready = !boundary;
    assign wr_accept = set_valid && set_ready;

    always_comb begin
        fcnt_d = fcnt_q + {{(FW-1){1'b0}}, 1'b1};
        if (boundary) begin
            fcnt_d = '0;
        end
    end

    // Reset parks the counter on the boundary so the first edge after release opens frame 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q        <= FW'(PERIOD_CYCLES - 1);
            frame_start_q <= 1'b0;
        end else begin
            fcnt_q        <= fcnt_d;
            frame_start_q <= boundary;
        end
    end

    assign frame_start = frame_start_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        servo_channel #(
            .POS_W         (POS_W),
            .PERIOD_CYCLES (PERIOD_CYCLES),
            .MIN_PULSE     (MIN_PULSE),
            .STEP_CYCLES   (STEP_CYCLES),
            .RAMP_FRAMES   (RAMP_FRAMES)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .boundary_i (boundary),
            .fcnt_i     (fcnt_q),
            .wr_i       (wr_accept && (set_chan == 3'(i))),
            .wr_snap_i  (set_snap),
            .wr_en_i    (set_en),
            .wr_value_i (set_value),
            .pwm_o      (pwm[i]),
            .settled_o  (settled[i])
        );
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb/tb_servo_pwm_multi.sv - randomized self-checking bench for servo_pwm_multi against a frame-level model
module tb_servo_pwm_multi;

    localparam int N_CH  = 4;
    localparam int POS_W = 8;
    localparam int P     = 300;
    localparam int MINP  = 10;
    localparam int STEP  = 1;
    localparam int RAMP  = 2;
    localparam int N_CYC = 60000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             set_valid = 1'b0;
    logic             set_ready;
    logic [2:0]       set_chan = '0;
    logic [POS_W-1:0] set_value = '0;
    logic             set_snap = 1'b0;
    logic             set_en = 1'b0;
    logic [N_CH-1:0]  pwm;
    logic [N_CH-1:0]  settled;
    logic             frame_start;

    always #5 clk = ~clk;

    servo_pwm_multi #(
        .N_CH          (N_CH),
        .POS_W         (POS_W),
        .PERIOD_CYCLES (P),
        .MIN_PULSE     (MINP),
        .STEP_CYCLES   (STEP),
        .RAMP_FRAMES   (RAMP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_valid   (set_valid),
        .set_ready   (set_ready),
        .set_chan    (set_chan),
        .set_value   (set_value),
        .set_snap    (set_snap),
        .set_en      (set_en),
        .pwm         (pwm),
        .settled     (settled),
        .frame_start (frame_start)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 20) begin
                $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
            end
        end
    endtask

    typedef struct {
        int chan;
        int val;
        bit snap;
        bit en;
    } wr_t;

    // Frame-level reference state
    int              m_fcnt;
    int              m_tgt   [N_CH];
    int              m_cur   [N_CH];
    int              m_frames[N_CH];
    int              m_w     [N_CH];
    bit              m_en_req[N_CH];
    bit              m_en_act[N_CH];
    logic [N_CH-1:0] m_settled;

    wr_t wq[$];
    wr_t cur_wr;
    bit  pend;
    bit  did_rst;

    task automatic model_reset();
        m_fcnt = P - 1;
        for (int i = 0; i < N_CH; i++) begin
            m_tgt[i] = 0; m_cur[i] = 0; m_frames[i] = 0; m_w[i] = MINP;
            m_en_req[i] = 0; m_en_act[i] = 0;
        end
        m_settled = '1;
    endtask

    function automatic logic [N_CH-1:0] exp_pwm();
        logic [N_CH-1:0] v;
        for (int i = 0; i < N_CH; i++) begin
            v[i] = m_en_act[i] && (m_fcnt < m_w[i]);
        end
        return v;
    endfunction

    task automatic check_outputs();
        check("pwm", 32'(pwm), 32'(exp_pwm()));
        check("settled", 32'(settled), 32'(m_settled));
        check("frame_start", 32'(frame_start), 32'(m_fcnt == 0));
        check("set_ready", 32'(set_ready), 32'(m_fcnt != P - 1));
    endtask

    // Advance the model across one clock edge given this cycle's accepted write.
    task automatic model_step(input bit acc, input wr_t w);
        logic [N_CH-1:0] s;
        for (int i = 0; i < N_CH; i++) s[i] = (m_cur[i] == m_tgt[i]);
        if (acc && w.chan < N_CH) begin
            m_tgt[w.chan]    = w.val;
            m_en_req[w.chan] = w.en;
            if (w.snap) m_cur[w.chan] = w.val;
        end
        if (m_fcnt == P - 1) begin
            for (int i = 0; i < N_CH; i++) begin
                if (m_en_act[i]) begin
                    m_frames[i]++;
                    if (m_frames[i] % RAMP == 0) begin
                        if (m_cur[i] < m_tgt[i]) m_cur[i]++;
                        else if (m_cur[i] > m_tgt[i]) m_cur[i]--;
                    end
                end else begin
                    m_frames[i] = 0;
                end
                m_en_act[i] = m_en_req[i];
                m_w[i] = MINP + m_cur[i] * STEP;
            end
            m_fcnt = 0;
        end else begin
            m_fcnt++;
        end
        m_settled = s;
    endtask

    task automatic push_random();
        wr_t w;
        int  v;
        w.chan = int'($urandom_range(0, 7));
        w.snap = ($urandom_range(0, 3) == 0);
        w.en   = ($urandom_range(0, 4) != 0);
        if (w.snap) begin
            v = int'($urandom_range(0, 255));
        end else begin
            v = m_cur[w.chan % N_CH] + int'($urandom_range(0, 8)) - 4;
            if (v < 0) v = 0;
            if (v > 255) v = 255;
        end
        w.val = v;
        wq.push_back(w);
    endtask

    initial begin
        bit acc;
        model_reset();
        pend = 0;
        did_rst = 0;
        wq.push_back('{0, 0, 1'b0, 1'b1});
        wq.push_back('{1, 5, 1'b0, 1'b1});
        wq.push_back('{2, 255, 1'b1, 1'b1});
        wq.push_back('{3, 40, 1'b1, 1'b1});
        wq.push_back('{6, 77, 1'b1, 1'b0});

        @(negedge clk);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < N_CYC; c++) begin
            check_outputs();

            if (!did_rst && c > 20000 && m_fcnt == 5 && exp_pwm() != '0) begin
                rst_n = 1'b0;
                #1;
                check("rst_pwm", 32'(pwm), 32'(0));
                check("rst_settled", 32'(settled), 32'({N_CH{1'b1}}));
                check("rst_ready", 32'(set_ready), 32'(0));
                check("rst_frame_start", 32'(frame_start), 32'(0));
                model_reset();
                wq.delete();
                pend = 0;
                set_valid = 1'b0;
                did_rst = 1;
                @(negedge clk);
                check_outputs();
                @(negedge clk);
                rst_n = 1'b1;
                continue;
            end

            if ($urandom_range(0, 59) == 0) push_random();
            if (m_fcnt == P - 1 && !pend && $urandom_range(0, 1) == 0) push_random();
            if (c == 30000) wq.push_back('{3, 40, 1'b0, 1'b0});

            if (!pend && wq.size() > 0) begin
                cur_wr = wq.pop_front();
                pend = 1;
            end

            set_valid = pend;
            if (pend) begin
                set_chan  = 3'(cur_wr.chan);
                set_value = POS_W'(cur_wr.val);
                set_snap  = cur_wr.snap;
                set_en    = cur_wr.en;
            end else begin
                set_chan  = 3'($urandom_range(0, 7));
                set_value = POS_W'($urandom_range(0, 255));
                set_snap  = 1'($urandom_range(0, 1));
                set_en    = 1'($urandom_range(0, 1));
            end

            acc = pend && (m_fcnt != P - 1);
            model_step(acc, cur_wr);
            if (acc) pend = 0;

            @(negedge clk);
        end

        check("reset_exercised", 32'(did_rst), 32'(1));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
